// File: rtl/stack_bus_pkg.sv
// Shared stack-bus definitions: lane framing codes, lane types and receiver FSM states.
// Reused by downstream lane and STU blocks.
package stack_bus_pkg;

  typedef enum logic [1:0] {
    CNTL_MOD     = 2'b00,
    CNTL_SOD     = 2'b01,
    CNTL_EOD     = 2'b10,
    CNTL_SOD_EOD = 2'b11
  } cntl_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } lane_state_e;

  localparam logic [1:0] LANE_TYPE_CTRL_SCALAR = 2'b00;
  localparam logic [1:0] LANE_TYPE_CTRL_VECTOR = 2'b01;
  localparam logic [1:0] LANE_TYPE_DATA_SCALAR = 2'b10;
  localparam logic [1:0] LANE_TYPE_DATA_VECTOR = 2'b11;

  // True for codes that terminate a packet (EOD or single-word packet).
  function automatic logic cntl_closes_pkt(input cntl_e code);
    return (code == CNTL_EOD) || (code == CNTL_SOD_EOD);
  endfunction

endpackage

// File: rtl/stu_lane_fifo.sv
// Synchronous first-word-fall-through FIFO; head reads as zero while empty.
// Also reports next-cycle occupancy so the owner can register its ready.
module stu_lane_fifo #(
  parameter int WIDTH = 68,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    count_next,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             push_eff;
  logic             pop_eff;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(DEPTH));
  assign count = count_reg;

  assign pop_eff  = pop & ~empty;
  // A push into a full FIFO is only honoured when the head leaves in the same cycle.
  assign push_eff = push & (~full | pop_eff);

  always_comb begin
    count_next = count_reg;
    case ({push_eff, pop_eff})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  assign dout = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_eff) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_eff) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_eff)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/stu_lane_receiver.sv
// STU end of one PE result lane: framing check, FWFT buffering toward the aggregator,
// completed-packet counter and sticky framing-error flag.
module stu_lane_receiver
  import stack_bus_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNTL_W = 2,
  parameter int TYPE_W = 2,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset_poweron,
  input  logic [TYPE_W-1:0] pe__stu__lane_type,
  input  logic [CNTL_W-1:0] pe__stu__lane_result_cntl,
  input  logic [DATA_W-1:0] pe__stu__lane_result_data,
  input  logic [DATA_W-1:0] pe__stu__lane_result_data_mask,
  input  logic              pe__stu__lane_result_data_valid,
  output logic              stu__pe__lane_result_ready,
  output logic              stu__agg__valid,
  output logic [TYPE_W-1:0] stu__agg__type,
  output logic [CNTL_W-1:0] stu__agg__cntl,
  output logic [DATA_W-1:0] stu__agg__data,
  output logic [DATA_W-1:0] stu__agg__data_mask,
  input  logic              agg__stu__ready,
  input  logic              sys__stu__err_clr,
  output logic              stu__sys__framing_error,
  output logic [15:0]       stu__sys__pkt_count
);

  localparam int ENTRY_W = TYPE_W + CNTL_W + 2 * DATA_W;
  localparam int CW      = $clog2(DEPTH) + 1;

  lane_state_e       state_reg, state_next;
  logic              ready_reg;
  logic              err_reg;
  logic [15:0]       pkt_count_reg;

  logic              accept;
  logic              push;
  logic              pop;
  logic              err_event;
  logic              pkt_done;
  cntl_e             code;

  logic [ENTRY_W-1:0] fifo_din;
  logic [ENTRY_W-1:0] fifo_dout;
  logic [CW-1:0]      fifo_count;
  logic [CW-1:0]      fifo_count_next;
  logic               fifo_empty;
  logic               fifo_full;
  logic               fifo_unused;

  assign accept = pe__stu__lane_result_data_valid & ready_reg;
  assign code   = cntl_e'(pe__stu__lane_result_cntl[1:0]);

  always_comb begin
    state_next = state_reg;
    push       = 1'b0;
    err_event  = 1'b0;
    pkt_done   = 1'b0;
    if (accept) begin
      case (state_reg)
        ST_IDLE: begin
          if (code == CNTL_SOD) begin
            push       = 1'b1;
            state_next = ST_IN_PKT;
          end else if (code == CNTL_SOD_EOD) begin
            push     = 1'b1;
            pkt_done = 1'b1;
          end else begin
            // Mid/end word with no open packet: drop it and flag.
            err_event = 1'b1;
          end
        end
        ST_IN_PKT: begin
          push = 1'b1;
          // A new start inside an open packet truncates the previous one.
          err_event  = (code == CNTL_SOD) || (code == CNTL_SOD_EOD);
          pkt_done   = cntl_closes_pkt(code);
          state_next = cntl_closes_pkt(code) ? ST_IDLE : ST_IN_PKT;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      state_reg     <= ST_IDLE;
      ready_reg     <= 1'b0;
      err_reg       <= 1'b0;
      pkt_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      ready_reg <= (fifo_count_next < CW'(DEPTH));
      if (err_event) begin
        err_reg <= 1'b1;
      end else if (sys__stu__err_clr) begin
        err_reg <= 1'b0;
      end
      if (pkt_done) begin
        pkt_count_reg <= pkt_count_reg + 16'd1;
      end
    end
  end

  assign fifo_din = {pe__stu__lane_type, pe__stu__lane_result_cntl,
                     pe__stu__lane_result_data, pe__stu__lane_result_data_mask};
  assign pop      = ~fifo_empty & agg__stu__ready;

  stu_lane_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .srst       (reset_poweron),
    .push       (push),
    .pop        (pop),
    .din        (fifo_din),
    .dout       (fifo_dout),
    .count      (fifo_count),
    .count_next (fifo_count_next),
    .empty      (fifo_empty),
    .full       (fifo_full)
  );

  // Ready already guarantees room, so occupancy and full are informational here.
  assign fifo_unused = ^{fifo_count, fifo_full};

  assign stu__pe__lane_result_ready = ready_reg;
  assign stu__agg__valid            = ~fifo_empty;
  assign {stu__agg__type, stu__agg__cntl, stu__agg__data, stu__agg__data_mask} = fifo_dout;
  assign stu__sys__framing_error    = err_reg;
  assign stu__sys__pkt_count        = pkt_count_reg;

endmodule

// File: tb/tb_stu_lane_receiver.sv
// Directed bench for stu_lane_receiver: framing, backpressure, error flag, counter wrap, reset.
module tb_stu_lane_receiver;

  logic        clk = 1'b0;
  logic        reset_poweron;
  logic [1:0]  lane_type;
  logic [1:0]  cntl;
  logic [31:0] data;
  logic [31:0] mask;
  logic        valid;
  logic        ready;
  logic        agg_valid;
  logic [1:0]  agg_type;
  logic [1:0]  agg_cntl;
  logic [31:0] agg_data;
  logic [31:0] agg_mask;
  logic        agg_ready;
  logic        err_clr;
  logic        err;
  logic [15:0] pkt_count;

  int total = 0;
  int bad   = 0;
  int exp_pkts = 0;

  always #5 clk = ~clk;

  stu_lane_receiver #(.DATA_W(32), .CNTL_W(2), .TYPE_W(2), .DEPTH(8)) dut (
    .clk                             (clk),
    .reset_poweron                   (reset_poweron),
    .pe__stu__lane_type              (lane_type),
    .pe__stu__lane_result_cntl       (cntl),
    .pe__stu__lane_result_data       (data),
    .pe__stu__lane_result_data_mask  (mask),
    .pe__stu__lane_result_data_valid (valid),
    .stu__pe__lane_result_ready      (ready),
    .stu__agg__valid                 (agg_valid),
    .stu__agg__type                  (agg_type),
    .stu__agg__cntl                  (agg_cntl),
    .stu__agg__data                  (agg_data),
    .stu__agg__data_mask             (agg_mask),
    .agg__stu__ready                 (agg_ready),
    .sys__stu__err_clr               (err_clr),
    .stu__sys__framing_error         (err),
    .stu__sys__pkt_count             (pkt_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drive(input logic [1:0] c, input logic [31:0] d);
    valid = 1'b1;
    cntl  = c;
    data  = d;
    mask  = ~d;
  endtask

  initial begin
    reset_poweron = 1'b1;
    lane_type = 2'b00; cntl = 2'b00; data = '0; mask = '0;
    valid = 1'b0; agg_ready = 1'b0; err_clr = 1'b0;
    tick(); tick();
    check("rst_ready", ready, 0);
    check("rst_valid", agg_valid, 0);
    check("rst_data", agg_data, 0);
    check("rst_type", agg_type, 0);
    check("rst_err", err, 0);
    check("rst_count", pkt_count, 0);
    reset_poweron = 1'b0;
    check("ready_first_cycle", ready, 0);
    tick();
    check("ready_after", ready, 1);

    // 4-word packet, aggregator always ready
    agg_ready = 1'b1;
    lane_type = 2'b11;
    drive(2'b01, 32'h11); tick();
    check("pkt_w0_valid", agg_valid, 1);
    check("pkt_w0_data", agg_data, 32'h11);
    check("pkt_w0_cntl", agg_cntl, 2'b01);
    check("pkt_w0_type", agg_type, 2'b11);
    check("pkt_w0_mask", agg_mask, ~32'h11);
    lane_type = 2'b10;
    drive(2'b00, 32'h22); tick();
    check("pkt_w1_data", agg_data, 32'h22);
    check("pkt_w1_type", agg_type, 2'b10);
    drive(2'b00, 32'h33); tick();
    check("pkt_w2_data", agg_data, 32'h33);
    drive(2'b10, 32'h44); tick();
    check("pkt_w3_data", agg_data, 32'h44);
    check("pkt_w3_cntl", agg_cntl, 2'b10);
    exp_pkts = 1;
    valid = 1'b0; tick();
    check("pkt_drained", agg_valid, 0);
    check("pkt_count1", pkt_count, 16'(exp_pkts));
    check("pkt_err0", err, 0);

    // Backpressure: fill to DEPTH with single-word packets
    agg_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(2'b11, 32'h100 + 32'(i)); tick();
      check("bp_ready", ready, (i < 7) ? 32'd1 : 32'd0);
    end
    exp_pkts += 8;
    drive(2'b11, 32'h1FF); tick(); tick();
    check("bp_ready_held_low", ready, 0);
    check("bp_head", agg_data, 32'h100);
    check("bp_count", pkt_count, 16'(exp_pkts));
    valid = 1'b0;
    agg_ready = 1'b1; tick();
    agg_ready = 1'b0;
    check("bp_ready_after_pop", ready, 1);
    check("bp_head_after_pop", agg_data, 32'h101);
    agg_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      check("bp_drain_data", agg_data, 32'h100 + 32'(i));
      tick();
    end
    check("bp_empty", agg_valid, 0);

    // Middle-of-data word in IDLE is dropped and flagged
    drive(2'b00, 32'hAA); tick();
    valid = 1'b0;
    check("idle_mod_dropped", agg_valid, 0);
    check("idle_mod_err", err, 1);
    check("idle_mod_count", pkt_count, 16'(exp_pkts));
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("err_clr", err, 0);
    drive(2'b10, 32'hBB); err_clr = 1'b1; tick();
    valid = 1'b0; err_clr = 1'b0;
    check("err_set_wins", err, 1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("err_clr2", err, 0);

    // SOD, MOD, SOD_EOD: all forwarded, error, counted
    drive(2'b01, 32'h51); tick();
    check("trunc_w0", agg_data, 32'h51);
    drive(2'b00, 32'h52); tick();
    check("trunc_w1", agg_data, 32'h52);
    drive(2'b11, 32'h53); tick();
    check("trunc_w2", agg_data, 32'h53);
    check("trunc_err", err, 1);
    exp_pkts += 1;
    check("trunc_count", pkt_count, 16'(exp_pkts));
    valid = 1'b0; err_clr = 1'b1; tick(); err_clr = 1'b0;
    drive(2'b01, 32'h61); tick();
    check("clean_sod_err", err, 0);
    check("clean_sod_data", agg_data, 32'h61);
    drive(2'b10, 32'h62); tick();
    valid = 1'b0;
    exp_pkts += 1;
    check("clean_eod_err", err, 0);
    check("clean_eod_count", pkt_count, 16'(exp_pkts));

    // Counter wrap
    drive(2'b11, 32'h7); 
    for (int i = exp_pkts; i < 65535; i++) tick();
    valid = 1'b0;
    check("wrap_ffff", pkt_count, 16'hFFFF);
    check("wrap_ready", ready, 1);
    drive(2'b11, 32'h8); tick();
    valid = 1'b0;
    check("wrap_zero", pkt_count, 16'h0000);
    tick();

    // Reset mid-packet
    agg_ready = 1'b0;
    drive(2'b01, 32'h71); tick();
    drive(2'b00, 32'h72); tick();
    valid = 1'b0;
    check("mid_valid", agg_valid, 1);
    reset_poweron = 1'b1; tick(); reset_poweron = 1'b0;
    check("mid_rst_valid", agg_valid, 0);
    check("mid_rst_ready", ready, 0);
    check("mid_rst_data", agg_data, 0);
    tick();
    check("mid_rst_ready1", ready, 1);
    drive(2'b10, 32'h73); tick();
    valid = 1'b0;
    check("mid_eod_err", err, 1);
    check("mid_eod_dropped", agg_valid, 0);
    check("mid_eod_count", pkt_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
